// File: rtl/ccd_timing_gen_if.sv
// Control/status bundle between the sequencer registers and the CCD timing generator.
// The master drives the frame request and geometry. The slave returns drive clocks, ADC strobe and status.
interface ccd_timing_gen_if #(
    parameter int CNT_W = 8,
    parameter int COL_W = 10,
    parameter int ROW_W = 10
);
    logic             start;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] p_width;
    logic [CNT_W-1:0] r_width;
    logic [COL_W-1:0] n_cols;
    logic [ROW_W-1:0] n_rows;

    logic             phi_p;
    logic             phi_l1;
    logic             phi_l2;
    logic             phi_r;
    logic             sample;
    logic [COL_W-1:0] col_idx;
    logic [ROW_W-1:0] row_idx;
    logic             busy;
    logic             done;

    modport master (
        output start, div, p_width, r_width, n_cols, n_rows,
        input  phi_p, phi_l1, phi_l2, phi_r, sample, col_idx, row_idx, busy, done
    );

    modport slave (
        input  start, div, p_width, r_width, n_cols, n_rows,
        output phi_p, phi_l1, phi_l2, phi_r, sample, col_idx, row_idx, busy, done
    );
endinterface

// File: rtl/ccd_timing_gen.sv
// CCD frame timing generator: phi_p / phi_l1 / phi_l2 / phi_r clocks, ADC sample strobe, busy/done.
// Latency: start sampled on an edge gives busy and phi_p in the next cycle; every output is registered.
// Backpressure: none; start is ignored while a frame runs and during the done cycle.
module ccd_timing_gen #(
    parameter int CNT_W = 8,
    parameter int COL_W = 10,
    parameter int ROW_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    ccd_timing_gen_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PAR  = 3'd1,
        S_GAP  = 3'd2,
        S_SER1 = 3'd3,
        S_SER2 = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Shadow config: effective (clamped) values latched when a frame is accepted.
    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] p_width;
        logic [CNT_W-1:0] r_width;
        logic [COL_W-1:0] n_cols;
        logic [ROW_W-1:0] n_rows;
    } cfg_t;

    localparam logic [CNT_W-1:0] ONE_CNT = 1;
    localparam logic [COL_W-1:0] ONE_COL = 1;
    localparam logic [ROW_W-1:0] ONE_ROW = 1;

    state_t           state, state_nxt;
    cfg_t             cfg, cfg_nxt, cfg_in;
    logic [CNT_W-1:0] tmr, tmr_nxt;
    logic [COL_W-1:0] col_q, col_nxt;
    logic [ROW_W-1:0] row_q, row_nxt;

    logic phi_p_q, phi_l1_q, phi_l2_q, phi_r_q, sample_q, busy_q, done_q;
    logic phi_p_d, phi_l1_d, phi_l2_d, phi_r_d, sample_d, busy_d, done_d;

    always_comb begin
        cfg_in         = '0;
        cfg_in.div     = (bus.div == '0) ? ONE_CNT : bus.div;
        cfg_in.p_width = (bus.p_width == '0) ? ONE_CNT : bus.p_width;
        cfg_in.r_width = (bus.r_width > cfg_in.div) ? cfg_in.div : bus.r_width;
        cfg_in.n_cols  = bus.n_cols;
        cfg_in.n_rows  = bus.n_rows;
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        col_nxt   = col_q;
        row_nxt   = row_q;
        cfg_nxt   = cfg;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    cfg_nxt = cfg_in;
                    tmr_nxt = '0;
                    if (bus.n_cols == '0 || bus.n_rows == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_PAR;
                    end
                end
            end
            S_PAR: begin
                if (tmr == cfg.p_width - ONE_CNT) begin
                    tmr_nxt   = '0;
                    state_nxt = S_GAP;
                end else begin
                    tmr_nxt = tmr + ONE_CNT;
                end
            end
            S_GAP: begin
                if (tmr == cfg.div - ONE_CNT) begin
                    tmr_nxt   = '0;
                    state_nxt = S_SER1;
                end else begin
                    tmr_nxt = tmr + ONE_CNT;
                end
            end
            S_SER1: begin
                if (tmr == cfg.div - ONE_CNT) begin
                    tmr_nxt   = '0;
                    state_nxt = S_SER2;
                end else begin
                    tmr_nxt = tmr + ONE_CNT;
                end
            end
            S_SER2: begin
                // Pixel ends on the sample cycle; advance column, then row.
                if (tmr == cfg.div - ONE_CNT) begin
                    tmr_nxt = '0;
                    if (col_q == cfg.n_cols - ONE_COL) begin
                        col_nxt = '0;
                        if (row_q == cfg.n_rows - ONE_ROW) begin
                            row_nxt   = '0;
                            state_nxt = S_DONE;
                        end else begin
                            row_nxt   = row_q + ONE_ROW;
                            state_nxt = S_PAR;
                        end
                    end else begin
                        col_nxt   = col_q + ONE_COL;
                        state_nxt = S_SER1;
                    end
                end else begin
                    tmr_nxt = tmr + ONE_CNT;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Outputs decode the state being entered so they land in registers aligned with it.
        phi_p_d  = (state_nxt == S_PAR);
        phi_l1_d = (state_nxt == S_SER1);
        phi_l2_d = (state_nxt == S_SER2);
        phi_r_d  = (state_nxt == S_SER1) && (tmr_nxt < cfg_nxt.r_width);
        sample_d = (state_nxt == S_SER2) && (tmr_nxt == cfg_nxt.div - ONE_CNT);
        busy_d   = (state_nxt == S_PAR) || (state_nxt == S_GAP) ||
                   (state_nxt == S_SER1) || (state_nxt == S_SER2);
        done_d   = (state_nxt == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cfg      <= '0;
            tmr      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            phi_p_q  <= 1'b0;
            phi_l1_q <= 1'b0;
            phi_l2_q <= 1'b0;
            phi_r_q  <= 1'b0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cfg      <= cfg_nxt;
            tmr      <= tmr_nxt;
            col_q    <= col_nxt;
            row_q    <= row_nxt;
            phi_p_q  <= phi_p_d;
            phi_l1_q <= phi_l1_d;
            phi_l2_q <= phi_l2_d;
            phi_r_q  <= phi_r_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.phi_p   = phi_p_q;
    assign bus.phi_l1  = phi_l1_q;
    assign bus.phi_l2  = phi_l2_q;
    assign bus.phi_r   = phi_r_q;
    assign bus.sample  = sample_q;
    assign bus.col_idx = col_q;
    assign bus.row_idx = row_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_ccd_timing_gen.sv
// Bench for ccd_timing_gen: frame-level reference model, event scoreboard and per-cycle waveform checks.
module tb_ccd_timing_gen;
    localparam int CNT_W = 8;
    localparam int COL_W = 10;
    localparam int ROW_W = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ccd_timing_gen_if #(.CNT_W(CNT_W), .COL_W(COL_W), .ROW_W(ROW_W)) bus ();

    ccd_timing_gen #(.CNT_W(CNT_W), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int c;
        bit is_done;
        int col;
        int row;
    } ev_t;
    ev_t exp_q[$];

    // Reference frame: effective params, start edge f_e (cyc value after it), done cycle f_dn.
    bit f_valid = 1'b0;
    bit f_zero  = 1'b0;
    bit in_rst  = 1'b1;
    int f_e, f_d, f_p, f_r, f_c, f_rows, f_l, f_dn;

    task automatic try_start();
        int e;
        ev_t ev;
        e = cyc + 1;
        if (in_rst) return;
        if (f_valid && e < f_dn + 2) return;
        f_valid = 1'b1;
        f_e     = e;
        f_d     = (bus.div == 0) ? 1 : int'(bus.div);
        f_p     = (bus.p_width == 0) ? 1 : int'(bus.p_width);
        f_r     = (int'(bus.r_width) > f_d) ? f_d : int'(bus.r_width);
        f_c     = int'(bus.n_cols);
        f_rows  = int'(bus.n_rows);
        f_zero  = (f_c == 0) || (f_rows == 0);
        f_l     = f_p + f_d + 2 * f_d * f_c;
        f_dn    = f_zero ? e : e + f_rows * f_l;
        if (!f_zero) begin
            for (int j = 0; j < f_rows; j++) begin
                for (int i = 0; i < f_c; i++) begin
                    ev.c = e - 1 + j * f_l + f_p + f_d + 2 * f_d * i + 2 * f_d;
                    ev.is_done = 1'b0;
                    ev.col = i;
                    ev.row = j;
                    exp_q.push_back(ev);
                end
            end
        end
        ev.c = f_dn;
        ev.is_done = 1'b1;
        ev.col = 0;
        ev.row = 0;
        exp_q.push_back(ev);
    endtask

    // v = {phi_p, phi_l1, phi_l2, phi_r, sample, busy, done}; t is the 1-based cycle within the frame.
    function automatic void expect_at(input int c, output logic [6:0] v, output int col, output int row);
        int t, u, s, w;
        v = '0;
        col = 0;
        row = 0;
        if (!f_valid) return;
        t = c - f_e + 1;
        if (f_zero) begin
            if (t == 1) v[0] = 1'b1;
            return;
        end
        if (t >= 1 && t <= f_rows * f_l) begin
            v[1] = 1'b1;
            u = (t - 1) % f_l;
            row = (t - 1) / f_l;
            if (u < f_p) begin
                v[6] = 1'b1;
            end else if (u >= f_p + f_d) begin
                s = u - f_p - f_d;
                col = s / (2 * f_d);
                w = s % (2 * f_d);
                if (w < f_d) begin
                    v[5] = 1'b1;
                    v[3] = (w < f_r);
                end else begin
                    v[4] = 1'b1;
                end
                v[2] = (w == 2 * f_d - 1);
            end
        end else if (t == f_rows * f_l + 1) begin
            v[0] = 1'b1;
        end
    endfunction

    initial begin
        logic [6:0] ev, act;
        int ec, er, nsamp, want;
        ev_t e;
        nsamp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                nsamp = 0;
            end else begin
                expect_at(cyc, ev, ec, er);
                act = {bus.phi_p, bus.phi_l1, bus.phi_l2, bus.phi_r, bus.sample, bus.busy, bus.done};
                checks++;
                if (act !== ev || int'(bus.col_idx) != ec || int'(bus.row_idx) != er) begin
                    errors++;
                    $display("FAIL wave cyc=%0d got ph=%b col=%0d row=%0d, want ph=%b col=%0d row=%0d",
                             cyc, act, bus.col_idx, bus.row_idx, ev, ec, er);
                end
                checks++;
                if ((bus.phi_l1 && bus.phi_l2) || (bus.phi_p && (bus.phi_l1 || bus.phi_l2)) ||
                    (bus.phi_r && !bus.phi_l1)) begin
                    errors++;
                    $display("FAIL invariant cyc=%0d got ph=%b, want no overlap and phi_r inside phi_l1",
                             cyc, act);
                end
                while (exp_q.size() != 0 && exp_q[0].c < cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL sb_missing event done=%0b col=%0d row=%0d expected at cyc=%0d, not observed",
                             e.is_done, e.col, e.row, e.c);
                end
                if (bus.sample || bus.done) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected cyc=%0d got sample=%0b done=%0b, want no event",
                                 cyc, bus.sample, bus.done);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.c != cyc || e.is_done != bus.done ||
                            (!e.is_done && (e.col != int'(bus.col_idx) || e.row != int'(bus.row_idx)))) begin
                            errors++;
                            $display("FAIL sb_event got cyc=%0d done=%0b col=%0d row=%0d, want cyc=%0d done=%0b col=%0d row=%0d",
                                     cyc, bus.done, bus.col_idx, bus.row_idx, e.c, e.is_done, e.col, e.row);
                        end
                    end
                end
                if (bus.sample) nsamp++;
                if (bus.done) begin
                    want = f_zero ? 0 : f_c * f_rows;
                    checks++;
                    if (nsamp != want) begin
                        errors++;
                        $display("FAIL sample_count cyc=%0d got %0d, want %0d", cyc, nsamp, want);
                    end
                    nsamp = 0;
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        checks++;
        if ({bus.phi_p, bus.phi_l1, bus.phi_l2, bus.phi_r, bus.sample, bus.busy, bus.done} != 7'd0 ||
            bus.col_idx != '0 || bus.row_idx != '0) begin
            errors++;
            $display("FAIL %s got ph=%b col=%0d row=%0d, want all zero", tag,
                     {bus.phi_p, bus.phi_l1, bus.phi_l2, bus.phi_r, bus.sample, bus.busy, bus.done},
                     bus.col_idx, bus.row_idx);
        end
    endtask

    task automatic set_cfg(input int d, input int p, input int r, input int c, input int rw);
        bus.div     = CNT_W'(d);
        bus.p_width = CNT_W'(p);
        bus.r_width = CNT_W'(r);
        bus.n_cols  = COL_W'(c);
        bus.n_rows  = ROW_W'(rw);
    endtask

    task automatic start_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.start = 1'b1;
            try_start();
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_frame();
        while (f_valid && cyc <= f_dn + 1) @(negedge clk);
    endtask

    task automatic run_frame(input int d, input int p, input int r, input int c, input int rw);
        set_cfg(d, p, r, c, rw);
        start_cycles(1);
        wait_frame();
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        @(posedge clk);
        #2 rst = 1'b0;
        in_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal frame with a second start and a div change while busy.
        set_cfg(2, 4, 1, 3, 2);
        start_cycles(1);
        repeat (8) @(negedge clk);
        bus.div = 8'd7;
        start_cycles(1);
        wait_frame();

        run_frame(0, 0, 5, 1, 1);
        run_frame(2, 2, 1, 3, 0);
        run_frame(3, 1, 2, 0, 4);

        // Start held through the done cycle: ignored there, accepted in the following idle cycle.
        set_cfg(1, 2, 1, 2, 1);
        start_cycles(1);
        while (cyc < f_dn - 1) @(negedge clk);
        start_cycles(2);
        wait_frame();

        // Reset during the serial phase of row 1, then a clean nominal frame.
        set_cfg(2, 4, 1, 3, 2);
        start_cycles(1);
        while (cyc < f_e + 26) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        f_valid = 1'b0;
        in_rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        in_rst = 1'b0;
        repeat (3) @(negedge clk);
        run_frame(2, 4, 1, 3, 2);

        run_frame(255, 255, 255, 2, 1);
        run_frame(1, 1, 1, 1023, 1);
        run_frame(1, 1, 0, 1, 1023);

        for (int k = 0; k < 12; k++) begin
            set_cfg(int'($urandom_range(1, 8)), int'($urandom_range(0, 8)), int'($urandom_range(0, 8)),
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
            start_cycles(int'($urandom_range(1, 3)));
            wait_frame();
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending events, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ccd_timing_gen.md
# ccd_timing_gen

Parametrised CCD readout timing generator. It produces the parallel-transfer (phi_p), two-phase horizontal-register (phi_l1/phi_l2) and reset-gate (phi_r) clocks for a full frame of programmable size. It also produces an ADC sample strobe and a start/busy/done handshake. It replaces the fixed-pattern signal generator in the CCD SoC sequencer path and sits between the control registers and the sensor drive pads / ADC trigger.

## Interface
- CNT_W, 8: width of phase-timing fields (div, p_width, r_width)
- COL_W, 10: width of column count and column index
- ROW_W, 10: width of row count and row index
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- start  in  1  frame request, sampled on rising edge; ignored while busy
- div  in  CNT_W  horizontal half-period in clk cycles (0 treated as 1)
- p_width  in  CNT_W  phi_p pulse width in clk cycles (0 treated as 1)
- r_width  in  CNT_W  phi_r pulse width in clk cycles (0 → no phi_r pulse; clipped to effective div)
- n_cols  in  COL_W  pixels per row
- n_rows  in  ROW_W  rows per frame
- phi_p  out  1  parallel (vertical) transfer clock
- phi_l1, phi_l2  out  1  horizontal register phases
- phi_r  out  1  output-node reset gate
- sample  out  1  one-cycle ADC strobe per pixel
- col_idx  out  COL_W  column of current pixel
- row_idx  out  ROW_W  row of current pixel
- busy  out  1  frame in progress
- done  out  1  one-cycle end-of-frame pulse

## Operation
- All outputs registered. On reset, every output is 0, the FSM is in IDLE and the internal counters are 0.
- At start, div, p_width, r_width, n_cols and n_rows are latched into shadow registers. Changes during the frame have no effect.
- **IDLE:** all phases 0.
  - start=1 with n_cols=0 or n_rows=0 → DONE directly, with no busy.
  - Otherwise → PAR.
- **PAR:** phi_p=1 for effective p_width cycles → GAP.
- **GAP:** all phases 0 for effective div cycles → SER. This guarantees non-overlap between phi_p and the L phases.
- **SER:** each pixel lasts 2·div cycles.
  - First div cycles: phi_l1=1, phi_l2=0. phi_r=1 during the first min(r_width, div) of those cycles.
  - Second div cycles: phi_l1=0, phi_l2=1.
  - sample=1 on the last cycle of the phi_l2 half.
  - col_idx increments after each sample and wraps to 0 after n_cols−1.
  - When the row ends: if row_idx < n_rows−1, increment row_idx → PAR; else → DONE.
- **DONE:** done=1 and busy=0 for one cycle, then → IDLE. row_idx and col_idx return to 0.
- Invariants:
  - phi_l1 & phi_l2 is never 1.
  - phi_p & (phi_l1 | phi_l2) is never 1.
  - phi_r is 1 only while phi_l1 is 1.
- Counters are sized to CNT_W / COL_W / ROW_W. Maximum values (all-ones) must not wrap early.

## Timing
- start sampled at edge 0 → busy=1 and phi_p=1 from cycle 1.
- Row length = p_width + div + 2·div·n_cols cycles (effective values).
- busy is high for n_rows × row length cycles. done is high in the following cycle, with busy already 0.
- A zero-size start at edge 0 gives done=1 in cycle 1 and busy stays 0.
- start asserted in the DONE cycle is ignored. start asserted in the first IDLE cycle after DONE is accepted.
- rst asserted mid-frame: all outputs go to 0 immediately (asynchronously). The block is in IDLE after rst deasserts and no done is issued.

## Test plan
- **Nominal frame:** div=2, p_width=4, r_width=1, n_cols=3, n_rows=2, start at edge 0.
  - Row is 18 cycles, busy high for cycles 1–36, done in cycle 37.
  - phi_p high in cycles 1–4 and 19–22.
  - 6 sample pulses; the first in cycle 10 with col_idx=0, row_idx=0.
- **Zero clamping:** div=0, p_width=0, r_width=5, n_cols=1, n_rows=1.
  - Expected sequence: phi_p 1 cycle, gap 1 cycle, phi_l1 1 cycle with phi_r=1, phi_l2 1 cycle with sample=1, done in cycle 5.
- **Zero-size frame:** n_rows=0 with start → done in cycle 1, busy never 1, all phases stay 0.
- **Busy and config isolation:** during the nominal frame, pulse start again and change div to 7.
  - Frame timing is unchanged and there is exactly one done.
- **Mid-frame reset:** rst during SER of row 1.
  - All outputs 0 immediately; no done.
  - A new start after reset produces a full nominal frame.
- **Invariant checker:** run throughout all scenarios, including random div/r_width in 1–8.
  - Assert phase non-overlap, phi_r ⊂ phi_l1, and sample count = n_cols·n_rows per frame.
